// File: rtl/adc_avg_pkg.sv
// Shared types and constants for the ADC boxcar moving-average filter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package adc_avg_pkg;

  localparam int DATA_W_DEF     = 8;
  localparam int LOG2_DEPTH_DEF = 3;
  localparam int ROUND_OFS_DEF  = 1 << (LOG2_DEPTH_DEF - 1);

  typedef enum logic [1:0] {
    ST_CLEAR  = 2'd0,
    ST_IDLE   = 2'd1,
    ST_UPDATE = 2'd2
  } avg_state_e;

  // Half of the window length, added before the shift so the mean rounds to nearest.
  function automatic int round_ofs(input int log2_depth);
    return 1 << (log2_depth - 1);
  endfunction

endpackage

// File: rtl/adc_avg_ring.sv
// Ring buffer of the last 2^LOG2_DEPTH samples with wrapping write pointer.
// Latency: write lands at the clock edge; rd_data (entry at wptr = oldest) is combinational.
// Backpressure: none; the owner decides when to write.
module adc_avg_ring
  import adc_avg_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int LOG2_DEPTH = LOG2_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ptr_clr,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              ptr_last
);

  localparam int DEPTH = 1 << LOG2_DEPTH;

  logic [DATA_W-1:0]     mem_q [DEPTH];
  logic [LOG2_DEPTH-1:0] wptr_q;

  // Write pointer: restarts at 0 on reset/clear, advances once per write and wraps naturally.
  always_ff @(posedge clk) begin
    if (reset || ptr_clr) begin
      wptr_q <= '0;
    end else if (wr_en) begin
      wptr_q <= wptr_q + 1'b1;
    end
  end

  // Storage has no reset; the CLEAR sweep in the owner zeroes every entry.
  always_ff @(posedge clk) begin
    if (wr_en && !reset && !ptr_clr) begin
      mem_q[wptr_q] <= wr_data;
    end
  end

  assign rd_data  = mem_q[wptr_q];
  assign ptr_last = (wptr_q == LOG2_DEPTH'(DEPTH - 1));

endmodule

// File: rtl/adc_moving_average.sv
// Boxcar moving-average of ADC samples; optional min/max tracking under ADC_AVG_MINMAX_EN.
// Latency: in_valid sampled at edge T -> out_valid/out_data registered at edge T+1.
// Backpressure: in_ready low in CLEAR/UPDATE; a sample offered then is dropped and sets overrun.
module adc_moving_average
  import adc_avg_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int LOG2_DEPTH = LOG2_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              filled,
  output logic              overrun
`ifdef ADC_AVG_MINMAX_EN
  ,
  output logic [DATA_W-1:0] min_data,
  output logic [DATA_W-1:0] max_data
`endif
);

  localparam int DEPTH = 1 << LOG2_DEPTH;
  localparam int SUM_W = DATA_W + LOG2_DEPTH;
  localparam int CNT_W = LOG2_DEPTH + 1;
  localparam logic [SUM_W-1:0] ROUND_OFS = SUM_W'(round_ofs(LOG2_DEPTH));
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DEPTH);

  avg_state_e        state_q, state_d;
  logic [DATA_W-1:0] sample_q, sample_d;
  logic [DATA_W-1:0] old_q, old_d;
  logic [SUM_W-1:0]  sum_q, sum_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              filled_q, filled_d;
  logic              overrun_q, overrun_d;
  logic [SUM_W-1:0]  new_sum;
  logic [SUM_W-1:0]  rounded;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] rd_data;
  logic              ptr_last;
`ifdef ADC_AVG_MINMAX_EN
  logic [DATA_W-1:0] min_q, min_d;
  logic [DATA_W-1:0] max_q, max_d;
`endif

  adc_avg_ring #(
    .DATA_W     (DATA_W),
    .LOG2_DEPTH (LOG2_DEPTH)
  ) u_ring (
    .clk      (clk),
    .reset    (reset),
    .ptr_clr  (clear),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .rd_data  (rd_data),
    .ptr_last (ptr_last)
  );

  // Next-state and datapath: clear wins over everything, then per-state actions.
  always_comb begin
    state_d     = state_q;
    sample_d    = sample_q;
    old_d       = old_q;
    sum_d       = sum_q;
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    filled_d    = filled_q;
    overrun_d   = overrun_q;
    wr_en       = 1'b0;
    wr_data     = in_data;
    in_ready    = (state_q == ST_IDLE);
    new_sum     = sum_q + SUM_W'(sample_q) - SUM_W'(old_q);
    rounded     = new_sum + ROUND_OFS;
`ifdef ADC_AVG_MINMAX_EN
    min_d       = min_q;
    max_d       = max_q;
`endif
    if (clear) begin
      state_d    = ST_CLEAR;
      sum_d      = '0;
      cnt_d      = '0;
      out_data_d = '0;
      filled_d   = 1'b0;
      overrun_d  = 1'b0;
`ifdef ADC_AVG_MINMAX_EN
      min_d      = '1;
      max_d      = '0;
`endif
    end else begin
      if (in_valid && !in_ready) begin
        overrun_d = 1'b1;
      end
      case (state_q)
        ST_CLEAR: begin
          wr_en   = 1'b1;
          wr_data = '0;
          if (ptr_last) begin
            state_d = ST_IDLE;
          end
        end
        ST_IDLE: begin
          if (in_valid) begin
            sample_d = in_data;
            old_d    = rd_data;
            wr_en    = 1'b1;
            if (cnt_q != CNT_FULL) begin
              cnt_d = cnt_q + 1'b1;
            end
`ifdef ADC_AVG_MINMAX_EN
            if (in_data < min_q) min_d = in_data;
            if (in_data > max_q) max_d = in_data;
`endif
            state_d = ST_UPDATE;
          end
        end
        ST_UPDATE: begin
          sum_d       = new_sum;
          out_data_d  = rounded[SUM_W-1:LOG2_DEPTH];
          out_valid_d = 1'b1;
          if (cnt_q == CNT_FULL) begin
            filled_d = 1'b1;
          end
          state_d = ST_IDLE;
        end
        default: state_d = ST_CLEAR;
      endcase
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_CLEAR;
      sample_q    <= '0;
      old_q       <= '0;
      sum_q       <= '0;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      filled_q    <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef ADC_AVG_MINMAX_EN
      min_q       <= '1;
      max_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      sample_q    <= sample_d;
      old_q       <= old_d;
      sum_q       <= sum_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      filled_q    <= filled_d;
      overrun_q   <= overrun_d;
`ifdef ADC_AVG_MINMAX_EN
      min_q       <= min_d;
      max_q       <= max_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign filled    = filled_q;
  assign overrun   = overrun_q;
`ifdef ADC_AVG_MINMAX_EN
  assign min_data  = min_q;
  assign max_data  = max_q;
`endif

endmodule

// File: tb/tb_adc_moving_average.sv
// Self-checking bench for adc_moving_average against a window-queue reference model.
// Latency: checks out_valid two clocks after each accepted in_valid.
// Backpressure: exercises dropped samples (overrun) and clear during UPDATE.
module tb_adc_moving_average;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 8;

  logic              clk;
  logic              reset;
  logic              clear;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              filled;
  logic              overrun;
`ifdef ADC_AVG_MINMAX_EN
  logic [DATA_W-1:0] min_data;
  logic [DATA_W-1:0] max_data;
`endif

  adc_moving_average dut (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .filled    (filled),
    .overrun   (overrun)
`ifdef ADC_AVG_MINMAX_EN
    ,
    .min_data  (min_data),
    .max_data  (max_data)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: the literal list of the last DEPTH samples.
  int win[$];
  int m_cnt;
  int m_out;
  int m_filled;
  int m_overrun;
  int m_min;
  int m_max;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int model_mean();
    int s = 0;
    foreach (win[i]) s += win[i];
    return (s + DEPTH / 2) / DEPTH;
  endfunction

  task automatic model_init();
    win.delete();
    for (int i = 0; i < DEPTH; i++) win.push_back(0);
    m_cnt = 0; m_out = 0; m_filled = 0; m_overrun = 0;
    m_min = 255; m_max = 0;
  endtask

  task automatic model_accept(input int v);
    void'(win.pop_front());
    win.push_back(v);
    if (m_cnt < DEPTH) m_cnt++;
    if (v < m_min) m_min = v;
    if (v > m_max) m_max = v;
  endtask

  task automatic model_update();
    m_out = model_mean();
    if (m_cnt == DEPTH) m_filled = 1;
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_vld"},     out_valid, 0);
    check({tag, "_dat"},     out_data, 0);
    check({tag, "_filled"},  filled, 0);
    check({tag, "_overrun"}, overrun, 0);
    check({tag, "_rdy"},     in_ready, 0);
`ifdef ADC_AVG_MINMAX_EN
    check({tag, "_min"},     min_data, 255);
    check({tag, "_max"},     max_data, 0);
`endif
  endtask

  // Initialisation sweep: in_ready must stay low for exactly DEPTH-1 cycles, high after DEPTH.
  task automatic wait_init();
    for (int k = 1; k <= DEPTH; k++) begin
      tick();
      check("init_rdy", in_ready, (k == DEPTH));
      check("init_vld", out_valid, 0);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    check_cleared("reset");
    reset = 1'b0;
    model_init();
    wait_init();
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check_cleared("clear");
    model_init();
    wait_init();
  endtask

  task automatic send(input int v, input int gap);
    check("send_rdy", in_ready, 1);
    in_valid = 1'b1;
    in_data  = DATA_W'(v);
    tick();
    in_valid = 1'b0;
    model_accept(v);
    check("acc_rdy", in_ready, 0);
    check("acc_vld", out_valid, 0);
`ifdef ADC_AVG_MINMAX_EN
    check("acc_min", min_data, m_min);
    check("acc_max", max_data, m_max);
`endif
    tick();
    model_update();
    check("upd_vld", out_valid, 1);
    check("upd_dat", out_data, m_out);
    check("upd_filled", filled, m_filled);
    check("upd_overrun", overrun, m_overrun);
    for (int g = 0; g < gap; g++) begin
      tick();
      check("gap_vld", out_valid, 0);
      check("gap_dat", out_data, m_out);
    end
  endtask

  // Second in_valid on the cycle right after an accepted one must be dropped.
  task automatic send_back_to_back(input int v1, input int v2);
    check("b2b_rdy", in_ready, 1);
    in_valid = 1'b1;
    in_data  = DATA_W'(v1);
    tick();
    model_accept(v1);
    in_data  = DATA_W'(v2);
    tick();
    in_valid = 1'b0;
    model_update();
    m_overrun = 1;
    check("b2b_vld", out_valid, 1);
    check("b2b_dat", out_data, m_out);
    check("b2b_overrun", overrun, 1);
    check("b2b_rdy2", in_ready, 1);
  endtask

  initial begin
    reset    = 1'b1;
    clear    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    model_init();

    do_reset();

    // Ramp up with 200s, then the window wraps and drains with 0s.
    for (int i = 0; i < DEPTH; i++) begin
      send(200, 2);
      check("ramp200", out_data, 25 * (i + 1));
      check("ramp_filled", filled, (i == DEPTH - 1));
    end
    for (int i = 0; i < DEPTH; i++) begin
      send(0, 2);
      check("drain0", out_data, 175 - 25 * i);
      check("drain_filled", filled, 1);
    end

    // Full-scale input must not overflow.
    for (int i = 0; i < DEPTH; i++) send(255, 1);
    check("full_scale", out_data, 255);

    // Rounding: sum of 4 over 8 rounds up to 1.
    do_clear();
    for (int i = 0; i < DEPTH - 1; i++) send(0, 0);
    send(4, 0);
    check("round_up", out_data, 1);

    // Dropped sample and sticky overrun, then clear releases it.
    send_back_to_back(80, 240);
    send(16, 1);
    check("overrun_sticky", overrun, 1);
    do_clear();

    // Clear landing on the UPDATE cycle suppresses the output pulse.
    send(120, 0);
    check("pre_clr_dat", out_data, 15);
    in_valid = 1'b1;
    in_data  = 8'd200;
    tick();
    in_valid = 1'b0;
    clear    = 1'b1;
    tick();
    clear    = 1'b0;
    check_cleared("clr_upd");
    model_init();
    wait_init();

`ifdef ADC_AVG_MINMAX_EN
    send(10, 0);
    send(250, 0);
    send(3, 0);
    check("mm_min", min_data, 3);
    check("mm_max", max_data, 250);
    do_clear();
`endif

    // Randomised traffic with occasional clears and dropped samples.
    for (int n = 0; n < 60; n++) begin
      int r;
      r = $urandom_range(0, 15);
      if (r == 0) begin
        do_clear();
      end else if (r == 1) begin
        send_back_to_back($urandom_range(0, 255), $urandom_range(0, 255));
      end else begin
        send($urandom_range(0, 255), $urandom_range(0, 3));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/adc_moving_average.md
# adc_moving_average

Boxcar moving-average filter between the ADC0808 capture interface and the binary-to-BCD display path. Accepts one 8-bit conversion result per valid pulse and keeps the last 2^LOG2_DEPTH samples in a ring buffer. Maintains a running sum and emits the rounded window mean with a one-cycle valid pulse, so the 7-segment readout stops flickering on noisy analog inputs.

## Interface
- DATA_W, 8: sample width in bits.
- LOG2_DEPTH, 3: log2 of the window length; DEPTH = 2^LOG2_DEPTH (8 by default).
- clk  input  1: single clock, the same domain as the ADC capture logic.
- reset  input  1: synchronous, active-high reset.
- clear  input  1: synchronous datapath clear; same effect as reset on buffer, sum, flags.
- in_valid  input  1: single-cycle pulse, new conversion result present.
- in_data  input  DATA_W: raw ADC sample.
- in_ready  output  1: high when a sample can be accepted this cycle.
- out_valid  output  1: single-cycle pulse, out_data updated.
- out_data  output  DATA_W: rounded window mean, held between pulses.
- filled  output  1: DEPTH samples accepted since last reset/clear.
- overrun  output  1: sticky; an in_valid arrived while in_ready was low.

## Operation
- Sum width is DATA_W+LOG2_DEPTH. Computation: mean = (sum + DEPTH/2) >> LOG2_DEPTH.
  - Maximum value (DEPTH·(2^DATA_W−1)+DEPTH/2) fits in that width.
  - The result never exceeds 2^DATA_W−1, so no saturation logic is needed.
- FSM states: CLEAR, IDLE, UPDATE.
  - CLEAR: writes 0 to one buffer entry per cycle, DEPTH cycles. wptr advances from 0 and wraps to 0. Then goes to IDLE. in_ready=0.
  - IDLE: in_ready=1. On in_valid:
    - sample_reg<=in_data and old_reg<=buf[wptr];
    - buf[wptr]<=in_data and wptr<=wptr+1 (wraps mod DEPTH);
    - count saturates at DEPTH; go to UPDATE.
  - UPDATE: in_ready=0.
    - sum<=sum+sample_reg−old_reg;
    - out_data<=rounded mean of the new sum; out_valid<=1 for one cycle;
    - go to IDLE.
- The buffer starts zeroed, so the output ramps up over the first DEPTH samples. filled rises with the update of sample number DEPTH.
- in_valid while in_ready=0: sample dropped; overrun<=1; no other state change.
- clear or reset in any state (including UPDATE):
  - go to CLEAR, wptr=0, sum=0, count=0, out_data=0;
  - filled=0, overrun=0;
  - suppress any pending out_valid.
  - reset has priority over clear. clear has priority over in_valid.

## Timing
- Reset values: in_ready=0, out_valid=0, out_data=0, filled=0, overrun=0; state CLEAR.
- After reset/clear deassertion, in_ready rises after exactly DEPTH cycles.
- Latency: in_valid sampled at edge T; out_valid high during the cycle after edge T+1 (2 clocks).
- Minimum input spacing is 2 cycles. At 50 kHz conversions this is never a constraint.
- out_data changes only together with out_valid, or on reset/clear.

## Configuration
- ADC_AVG_MINMAX_EN defined: adds outputs min_data and max_data (DATA_W each).
  - They track the raw accepted samples since reset/clear and update at the same edge the sample is accepted.
  - Reset/clear values: min_data = all ones, max_data = 0.
- Undefined: ports and tracking logic are absent; all other behaviour is identical.

## Structure
- Shared package adc_avg_pkg: FSM state enum, DATA_W/LOG2_DEPTH default constants, rounding-offset constant.
- One sub-module: adc_avg_ring. It holds the DEPTH×DATA_W storage, write pointer with wrap, and the combinational read of the oldest entry. The FSM, sum and flags live in the top.

## Test plan
- Reset held 2 cycles, then released:
  - in_ready stays 0 for 8 cycles, then goes 1;
  - out_data=0, filled=0, overrun=0.
- Eight samples of 200, spaced 4 cycles:
  - out_data sequence 25,50,75,100,125,150,175,200, each 2 clocks after its in_valid;
  - filled rises with the 8th.
- Then eight samples of 0:
  - outputs 175,150,125,100,75,50,25,0;
  - filled stays 1 (wrap-around of wptr).
- Rounding and width:
  - eight samples of 255 → 255;
  - after clear, seven 0s then one 4 → sum 4 → out_data 1.
- in_valid on the cycle immediately after an accepted one:
  - second sample dropped, overrun=1, next output reflects only the first;
  - clear drops overrun to 0.
- clear asserted during UPDATE:
  - no out_valid; out_data=0;
  - in_ready returns after 8 cycles.
  - With ADC_AVG_MINMAX_EN, samples 10,250,3 give min_data=3 and max_data=250; a subsequent clear restores 255/0.
